layer_header_bank: RTL

- Parametrised, double-buffered layer header register file for the GPU layer pipeline.
- The controller reads and writes a shadow bank one register at a time.
- The render pipeline reads whole headers from an active bank.
- The active bank is updated atomically from the shadow bank on a frame-boundary commit.
- A sequencer clears headers to zero, either for one layer or sweeping all layers.

---
 rtl/layer_header_bank.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/layer_header_bank.sv
// Double-buffered layer header register file.
// The controller edits a shadow bank one register at a time, the render
// pipeline reads whole headers from an active bank, and a frame-boundary
// commit copies shadow to active in one edge. A small sequencer zeroes
// headers in both banks, one layer per cycle.
module layer_header_bank #(
    parameter int NUM_LAYERS = 32,
    parameter int NUM_REGS   = 8,
    parameter int REG_WIDTH  = 16,
    parameter int LAYER_AW   = 5,
    parameter int REG_AW     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pipe_rd_en,
    input  logic [LAYER_AW-1:0]           pipe_layer,
    output logic [NUM_REGS*REG_WIDTH-1:0] pipe_info,
    output logic                          pipe_valid,
    input  logic [LAYER_AW-1:0]           ctrl_layer,
    input  logic [REG_AW-1:0]             ctrl_reg,
    input  logic                          ctrl_wr_en,
    input  logic [REG_WIDTH-1:0]          ctrl_wr_data,
    input  logic                          ctrl_rd_en,
    output logic [REG_WIDTH-1:0]          ctrl_rd_data,
    output logic                          ctrl_rd_valid,
    input  logic                          clear_req,
    input  logic                          clear_all,
    output logic                          clear_busy,
    input  logic                          frame_commit,
    output logic                          commit_ack
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [LAYER_AW-1:0] LAST_LAYER = LAYER_AW'(NUM_LAYERS - 1);

    logic [REG_WIDTH-1:0] shadow_q [NUM_LAYERS][NUM_REGS];
    logic [REG_WIDTH-1:0] shadow_d [NUM_LAYERS][NUM_REGS];
    logic [REG_WIDTH-1:0] active_q [NUM_LAYERS][NUM_REGS];
    logic [REG_WIDTH-1:0] active_d [NUM_LAYERS][NUM_REGS];

    logic [0:0]          state_q, state_d;
    logic [LAYER_AW-1:0] clr_layer_q, clr_layer_d;
    logic [LAYER_AW-1:0] clr_end_q, clr_end_d;
    logic                pending_q, pending_d;
    logic                commit_ack_q, commit_ack_d;

    logic [NUM_REGS*REG_WIDTH-1:0] pipe_info_q, pipe_info_d;
    logic                          pipe_valid_q, pipe_valid_d;
    logic [REG_WIDTH-1:0]          ctrl_rd_data_q, ctrl_rd_data_d;
    logic                          ctrl_rd_valid_q, ctrl_rd_valid_d;

    logic busy;
    logic ctrl_layer_ok;
    logic ctrl_reg_ok;
    logic pipe_layer_ok;
    logic clr_layer_ok;
    logic commit_fire;
    logic wr_ok;

    // Decode address legality and the commit/write qualifiers shared by the blocks below
    always_comb begin
        busy          = (state_q == ST_CLEAR);
        ctrl_layer_ok = (32'(ctrl_layer)  < 32'(NUM_LAYERS));
        ctrl_reg_ok   = (32'(ctrl_reg)    < 32'(NUM_REGS));
        pipe_layer_ok = (32'(pipe_layer)  < 32'(NUM_LAYERS));
        clr_layer_ok  = (32'(clr_layer_q) < 32'(NUM_LAYERS));
        commit_fire   = !busy && (frame_commit || pending_q);
        wr_ok         = ctrl_wr_en && !busy && ctrl_layer_ok && ctrl_reg_ok;
    end

    // Next-state of both banks: commit copies the pre-write shadow, clears zero a layer, writes hit shadow only
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (commit_fire) begin
            active_d = shadow_q;
        end
        if (busy && clr_layer_ok) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                shadow_d[clr_layer_q][r] = '0;
                active_d[clr_layer_q][r] = '0;
            end
        end
        if (wr_ok) begin
            shadow_d[ctrl_layer][ctrl_reg] = ctrl_wr_data;
        end
    end

    // Bank storage; reset zeroes every header in both banks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    shadow_q[l][r] <= '0;
                    active_q[l][r] <= '0;
                end
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Clear sequencer: latch the layer range on request, then sweep one layer per cycle
    always_comb begin
        state_d     = state_q;
        clr_layer_d = clr_layer_q;
        clr_end_d   = clr_end_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    clr_layer_d = clear_all ? '0 : ctrl_layer;
                    clr_end_d   = clear_all ? LAST_LAYER : ctrl_layer;
                end
            end
            ST_CLEAR: begin
                if ((clr_layer_q == clr_end_q) || !clr_layer_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_layer_d = clr_layer_q + LAYER_AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A commit requested during a clear is remembered and retired in the first idle cycle
    always_comb begin
        pending_d    = busy ? (pending_q || frame_commit) : 1'b0;
        commit_ack_d = commit_fire;
    end

    // Sequencer and commit bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_layer_q  <= '0;
            clr_end_q    <= '0;
            pending_q    <= 1'b0;
            commit_ack_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_layer_q  <= clr_layer_d;
            clr_end_q    <= clr_end_d;
            pending_q    <= pending_d;
            commit_ack_q <= commit_ack_d;
        end
    end

    // Read ports: capture the current bank contents, hold the last result when idle
    always_comb begin
        pipe_valid_d    = pipe_rd_en;
        pipe_info_d     = pipe_info_q;
        ctrl_rd_valid_d = ctrl_rd_en;
        ctrl_rd_data_d  = ctrl_rd_data_q;
        if (pipe_rd_en) begin
            pipe_info_d = '0;
            if (pipe_layer_ok) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    pipe_info_d[k*REG_WIDTH +: REG_WIDTH] = active_q[pipe_layer][k];
                end
            end
        end
        if (ctrl_rd_en) begin
            ctrl_rd_data_d = '0;
            if (ctrl_layer_ok && ctrl_reg_ok) begin
                ctrl_rd_data_d = shadow_q[ctrl_layer][ctrl_reg];
            end
        end
    end

    // Registered read results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_info_q     <= '0;
            pipe_valid_q    <= 1'b0;
            ctrl_rd_data_q  <= '0;
            ctrl_rd_valid_q <= 1'b0;
        end else begin
            pipe_info_q     <= pipe_info_d;
            pipe_valid_q    <= pipe_valid_d;
            ctrl_rd_data_q  <= ctrl_rd_data_d;
            ctrl_rd_valid_q <= ctrl_rd_valid_d;
        end
    end

    assign pipe_info     = pipe_info_q;
    assign pipe_valid    = pipe_valid_q;
    assign ctrl_rd_data  = ctrl_rd_data_q;
    assign ctrl_rd_valid = ctrl_rd_valid_q;
    assign clear_busy    = busy;
    assign commit_ack    = commit_ack_q;

endmodule
